// File: rtl/bcd_stopwatch_timer_pkg.sv
// Shared types, constants and helpers for the BCD stopwatch/timer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } swState_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_59   = 8'h59;

    // True when both nibbles are decimal digits and the value does not exceed limit.
    // For valid BCD the plain binary compare orders values the same way as decimal.
    function automatic logic isValidBcd(input logic [7:0] value, input logic [7:0] limit);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
    endfunction

endpackage

// File: rtl/bcd_stopwatch_timer_if.sv
// Control and display bundle between the stopwatch core and its surroundings.
interface bcd_stopwatch_timer_if;

    logic       tickIn;
    logic       startStopBtn;
    logic       clearBtn;
    logic       loadBtn;
    logic       countDown;
    logic [7:0] presetMin;
    logic [7:0] presetSec;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       running;
    logic       alarm;
    logic       rolloverPulse;

    modport master (
        output tickIn, startStopBtn, clearBtn, loadBtn, countDown, presetMin, presetSec,
        input  minutes, seconds, running, alarm, rolloverPulse
    );

    modport slave (
        input  tickIn, startStopBtn, clearBtn, loadBtn, countDown, presetMin, presetSec,
        output minutes, seconds, running, alarm, rolloverPulse
    );

endinterface

// File: rtl/bcd_stopwatch_timer_bcd_pair_counter.sv
// Two-digit BCD up/down counter wrapping between 00 and a programmable limit.
// wrapOut flags that the current enabled step wraps (carry when counting up,
// borrow when counting down) so a higher-order pair can be chained.
module bcd_pair_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       resetSW,
    input  logic       enable,
    input  logic       countUp,
    input  logic       load,
    input  logic [7:0] loadValue,
    input  logic [7:0] limit,
    output logic [7:0] value,
    output logic       wrapOut,
    output logic       atZero
);

    logic [7:0] stepValue;

    // Value after one BCD step in the selected direction, wrapping at limit/zero.
    always_comb begin
        stepValue = value;
        if (countUp) begin
            if (value == limit) begin
                stepValue = BCD_ZERO;
            end else if (value[3:0] == 4'd9) begin
                stepValue = {value[7:4] + 4'd1, 4'd0};
            end else begin
                stepValue = {value[7:4], value[3:0] + 4'd1};
            end
        end else begin
            if (value == BCD_ZERO) begin
                stepValue = limit;
            end else if (value[3:0] == 4'd0) begin
                stepValue = {value[7:4] - 4'd1, 4'd9};
            end else begin
                stepValue = {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

    // Digit register: load beats stepping.
    always_ff @(posedge clk) begin
        if (resetSW) begin
            value <= BCD_ZERO;
        end else if (load) begin
            value <= loadValue;
        end else if (enable) begin
            value <= stepValue;
        end
    end

    assign atZero  = (value == BCD_ZERO);
    assign wrapOut = enable & (countUp ? (value == limit) : atZero);

endmodule

// File: rtl/bcd_stopwatch_timer.sv
// MM:SS stopwatch / countdown timer driven by an edge-detected slow tick.
// Everything runs on clk; tickIn is only ever sampled, never used as a clock.
module bcd_stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] MAX_MIN = 8'h59
)
(
    input  logic                  clk,
    input  logic                  resetSW,
    bcd_stopwatch_timer_if.slave  bus
);

    swState_t   state;
    swState_t   nextState;
    logic       modeReg;
    logic       modeLoad;
    logic       tickPrev;
    logic       tickPulse;
    logic       presetOk;
    logic       countEn;
    logic       digitLoad;
    logic [7:0] loadSec;
    logic [7:0] loadMin;
    logic [7:0] secValue;
    logic [7:0] minValue;
    logic       secWrap;
    logic       minWrap;
    logic       secAtZero;
    logic       minAtZero;
    logic       timeAtZero;
    logic       rollover;

    assign tickPulse  = bus.tickIn & ~tickPrev;
    assign presetOk   = isValidBcd(bus.presetSec, BCD_59) && isValidBcd(bus.presetMin, MAX_MIN);
    assign timeAtZero = secAtZero & minAtZero;
    assign rollover   = minWrap & ~modeReg;

    // Next-state and control decode, honouring clear > load > start/stop > tick.
    always_comb begin
        nextState = state;
        modeLoad  = 1'b0;
        countEn   = 1'b0;
        digitLoad = 1'b0;
        loadSec   = BCD_ZERO;
        loadMin   = BCD_ZERO;
        if (bus.clearBtn) begin
            digitLoad = 1'b1;
            nextState = ST_IDLE;
        end else if (bus.loadBtn && presetOk) begin
            digitLoad = 1'b1;
            loadSec   = bus.presetSec;
            loadMin   = bus.presetMin;
            nextState = ST_IDLE;
        end else begin
            countEn = (state == ST_RUN) && tickPulse;
            if (bus.startStopBtn) begin
                case (state)
                    ST_IDLE, ST_PAUSE: begin
                        if (!(bus.countDown && timeAtZero)) begin
                            nextState = ST_RUN;
                            modeLoad  = 1'b1;
                        end
                    end
                    ST_RUN:  nextState = ST_PAUSE;
                    default: nextState = state;
                endcase
            end
            if (countEn && modeReg && minAtZero && (secValue == 8'h01)) begin
                nextState = ST_EXPIRED;
            end
        end
    end

    // State, latched mode, tick history and registered status flags.
    always_ff @(posedge clk) begin
        if (resetSW) begin
            state             <= ST_IDLE;
            modeReg           <= 1'b0;
            tickPrev          <= 1'b1;
            bus.running       <= 1'b0;
            bus.alarm         <= 1'b0;
            bus.rolloverPulse <= 1'b0;
        end else begin
            state             <= nextState;
            tickPrev          <= bus.tickIn;
            bus.running       <= (nextState == ST_RUN);
            bus.alarm         <= (nextState == ST_EXPIRED);
            bus.rolloverPulse <= rollover;
            if (modeLoad) begin
                modeReg <= bus.countDown;
            end
        end
    end

    bcd_pair_counter secCounter (
        .clk       (clk),
        .resetSW   (resetSW),
        .enable    (countEn),
        .countUp   (~modeReg),
        .load      (digitLoad),
        .loadValue (loadSec),
        .limit     (BCD_59),
        .value     (secValue),
        .wrapOut   (secWrap),
        .atZero    (secAtZero)
    );

    bcd_pair_counter minCounter (
        .clk       (clk),
        .resetSW   (resetSW),
        .enable    (countEn & secWrap),
        .countUp   (~modeReg),
        .load      (digitLoad),
        .loadValue (loadMin),
        .limit     (MAX_MIN),
        .value     (minValue),
        .wrapOut   (minWrap),
        .atZero    (minAtZero)
    );

    assign bus.seconds = secValue;
    assign bus.minutes = minValue;

endmodule
